// File: rtl/ysyx_22041211_ifu_queue_if.sv
// Fetch-side bundle of the IFU: memory request/response, redirect, and decoder handoff.
// The master modport is the IFU's own view; slave is the memory/decoder/PC-logic view.
interface ysyx_22041211_ifu_queue_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                req_valid_o;
  logic                req_ready_i;
  logic [ADDR_LEN-1:0] req_addr_o;
  logic                rsp_valid_i;
  logic [DATA_LEN-1:0] rsp_data_i;
  logic                redirect_i;
  logic [ADDR_LEN-1:0] redirect_pc_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [DATA_LEN-1:0] inst_o;
  logic [ADDR_LEN-1:0] pc_o;
  logic                invalid_o;
  logic                halted_o;

  modport master (
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, invalid_o, halted_o,
    input  req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );

  modport slave (
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, pc_o, invalid_o, halted_o,
    output req_ready_i, rsp_valid_i, rsp_data_i, redirect_i, redirect_pc_i, inst_ready_i
  );
endinterface

// File: rtl/ysyx_22041211_ifu_queue.sv
// Decoupled instruction fetch with an in-order queue, redirect flush and ebreak halt.
// Define ILLEGAL_CHECK_EN to predecode each enqueued word and flag illegal instructions.
module ysyx_22041211_ifu_queue #(
  parameter int                  ADDR_LEN = 32,
  parameter int                  DATA_LEN = 32,
  parameter int                  DEPTH    = 4,
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h8000_0000
) (
  input logic                        clk,
  input logic                        rst,
  ysyx_22041211_ifu_queue_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]         DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [DATA_LEN-1:0] EBREAK  = DATA_LEN'(32'h0010_0073);

  typedef enum logic [1:0] {BOOT, FETCH, HALT} state_t;

  state_t              state;
  logic                halted;
  logic [ADDR_LEN-1:0] fetch_pc;
  logic [ADDR_LEN-1:0] resp_pc;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       discard;

  logic [DATA_LEN-1:0] q_inst [DEPTH];
  logic [ADDR_LEN-1:0] q_pc   [DEPTH];

  logic                inst_valid;
  logic                req_fire;
  logic                keep;
  logic                deq;
  logic [CW:0]         credit_used;
  logic [CW-1:0]       inflight_nxt;

  // Requests are credited against queue space so every kept response has a slot.
  assign credit_used     = {1'b0, count} + {1'b0, inflight};
  assign bus.req_valid_o = (state == FETCH) && (credit_used < DEPTH_C) && !bus.redirect_i;
  assign bus.req_addr_o  = fetch_pc;
  assign req_fire        = bus.req_valid_o && bus.req_ready_i;

  assign inst_valid       = (count != '0);
  assign deq              = inst_valid && bus.inst_ready_i;
  assign keep             = bus.rsp_valid_i && !bus.redirect_i && (discard == '0);
  assign inflight_nxt     = inflight + CW'(req_fire) - CW'(bus.rsp_valid_i);

  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = inst_valid ? q_inst[head] : '0;
  assign bus.pc_o         = inst_valid ? q_pc[head]   : '0;
  assign bus.halted_o     = halted;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= BOOT;
      halted   <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (bus.redirect_i) begin
        // Everything still in flight after this edge belongs to the wrong path.
        fetch_pc <= bus.redirect_pc_i;
        resp_pc  <= bus.redirect_pc_i;
        head     <= tail;
        count    <= '0;
        discard  <= inflight_nxt;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_LEN'(4);
        if (keep) begin
          tail    <= tail + PW'(1);
          resp_pc <= resp_pc + ADDR_LEN'(4);
        end
        if (bus.rsp_valid_i && (discard != '0)) discard <= discard - CW'(1);
        if (deq) head <= head + PW'(1);
        count <= count + CW'(keep) - CW'(deq);
      end

      case (state)
        BOOT:  state <= FETCH;
        FETCH: if (!bus.redirect_i && deq && (q_inst[head] == EBREAK)) begin
          state  <= HALT;
          halted <= 1'b1;
        end
        HALT:  if (bus.redirect_i) begin
          state  <= FETCH;
          halted <= 1'b0;
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      q_inst[tail] <= bus.rsp_data_i;
      q_pc[tail]   <= resp_pc;
    end
  end

`ifdef ILLEGAL_CHECK_EN
  function automatic logic is_illegal(input logic [31:0] w);
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3 = w[14:12];
    f7 = w[31:25];
    ok = 1'b0;
    case (w[6:0])
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100011, 7'b0110011: ok = 1'b1;
      7'b1100111: ok = (f3 == 3'd0);
      7'b0000011: ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      7'b0100011: ok = (f3 inside {3'd0, 3'd1, 3'd2});
      7'b0010011: begin
        case (f3)
          3'd1:    ok = (f7 == 7'h00);
          3'd5:    ok = (f7 == 7'h00) || (f7 == 7'h20);
          default: ok = 1'b1;
        endcase
      end
      7'b1110011: ok = (w == 32'h0000_0073) || (w == 32'h0010_0073) ||
                       (w == 32'h3020_0073) || ((f3 != 3'd0) && (f3 != 3'd4));
      default:    ok = 1'b0;
    endcase
    return !ok;
  endfunction

  logic q_inv [DEPTH];

  always_ff @(posedge clk) begin
    if (keep) q_inv[tail] <= is_illegal(bus.rsp_data_i);
  end

  assign bus.invalid_o = inst_valid && q_inv[head];
`else
  assign bus.invalid_o = 1'b0;
`endif
endmodule

// File: tb/tb_ysyx_22041211_ifu_queue.sv
// Directed bench for ysyx_22041211_ifu_queue: a 1-cycle memory model echoes the address
// as data (with a few substituted words), and each step checks outputs against hand values.
module tb_ysyx_22041211_ifu_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_22041211_ifu_queue_if bus ();

  ysyx_22041211_ifu_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef ILLEGAL_CHECK_EN
  localparam logic EXP_ILL0 = 1'b1;
`else
  localparam logic EXP_ILL0 = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  int          nreq   = 0;
  int          mode   = 0;
  bit          mem_auto = 1'b0;
  logic [31:0] pend [$];

  function automatic logic [31:0] memdata(input logic [31:0] a);
    if (mode == 1 && a == BASE + 32'd4) return EBREAK;
    if (mode == 2 && a == BASE)         return 32'h0000_0000;
    if (mode == 2 && a == BASE + 32'd4) return 32'h0000_0013;
    return a;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: record a handshake seen before the edge, then present the memory response.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    #1;
    hs = (bus.req_valid_o === 1'b1) && (bus.req_ready_i === 1'b1);
    a  = bus.req_addr_o;
    @(posedge clk);
    #1;
    if (hs) begin
      pend.push_back(a);
      nreq++;
    end
    if (mem_auto && pend.size() > 0) begin
      bus.rsp_valid_i = 1'b1;
      bus.rsp_data_i  = memdata(pend.pop_front());
    end else begin
      bus.rsp_valid_i = 1'b0;
    end
  endtask

  task automatic rsp_send();
    if (pend.size() > 0) begin
      bus.rsp_valid_i = 1'b1;
      bus.rsp_data_i  = memdata(pend.pop_front());
    end
  endtask

  task automatic reset_dut();
    rst             = 1'b0;
    mem_auto        = 1'b0;
    bus.redirect_i  = 1'b0;
    bus.rsp_valid_i = 1'b0;
    tick();
    tick();
    pend.delete();
    nreq            = 0;
    bus.rsp_valid_i = 1'b0;
    rst             = 1'b1;
  endtask

  task automatic wait_inst(input int maxc);
    for (int i = 0; i < maxc && bus.inst_valid_o !== 1'b1; i++) tick();
  endtask

  initial begin
    bus.req_ready_i   = 1'b1;
    bus.inst_ready_i  = 1'b1;
    bus.rsp_valid_i   = 1'b0;
    bus.rsp_data_i    = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;

    // Reset values, then the first-fetch timeline.
    mode = 0;
    reset_dut();
    check("rst_req_valid",  bus.req_valid_o,  0);
    check("rst_req_addr",   bus.req_addr_o,   BASE);
    check("rst_inst_valid", bus.inst_valid_o, 0);
    check("rst_inst",       bus.inst_o,       0);
    check("rst_pc",         bus.pc_o,         0);
    check("rst_invalid",    bus.invalid_o,    0);
    check("rst_halted",     bus.halted_o,     0);
    mem_auto = 1'b1;
    tick();
    check("c2_req_valid",   bus.req_valid_o,  1);
    check("c2_req_addr",    bus.req_addr_o,   BASE);
    tick();
    check("c3_req_addr",    bus.req_addr_o,   BASE + 32'h4);
    check("c3_inst_valid",  bus.inst_valid_o, 0);
    tick();
    check("c4_inst_valid",  bus.inst_valid_o, 1);
    check("c4_inst",        bus.inst_o,       BASE);
    check("c4_pc",          bus.pc_o,         BASE);
    tick();
    check("c5_inst",        bus.inst_o,       BASE + 32'h4);
    check("c5_pc",          bus.pc_o,         BASE + 32'h4);

    // Decoder stalled: exactly DEPTH requests, then in-order drain.
    bus.inst_ready_i = 1'b0;
    reset_dut();
    mem_auto = 1'b1;
    repeat (8) tick();
    check("full_nreq",       nreq,             4);
    check("full_req_valid",  bus.req_valid_o,  0);
    check("full_inst_valid", bus.inst_valid_o, 1);
    bus.inst_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_pc",   bus.pc_o,   BASE + 32'(4 * i));
      check("drain_inst", bus.inst_o, BASE + 32'(4 * i));
      tick();
    end

    // Redirect with three requests in flight.
    bus.inst_ready_i = 1'b0;
    reset_dut();
    repeat (4) tick();
    check("t3_inflight", nreq, 3);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = BASE + 32'h100;
    #1;
    check("t3_req_gated", bus.req_valid_o, 0);
    tick();
    bus.redirect_i = 1'b0;
    #1;
    check("t3_req_valid", bus.req_valid_o, 1);
    check("t3_req_addr",  bus.req_addr_o,  BASE + 32'h100);
    mem_auto = 1'b1;
    wait_inst(20);
    check("t3_valid", bus.inst_valid_o, 1);
    check("t3_pc",    bus.pc_o,         BASE + 32'h100);
    check("t3_inst",  bus.inst_o,       BASE + 32'h100);

    // Redirect coinciding with a response while the queue holds an entry.
    reset_dut();
    repeat (3) tick();
    rsp_send();
    tick();
    check("t4_head_valid", bus.inst_valid_o, 1);
    check("t4_head_pc",    bus.pc_o,         BASE);
    rsp_send();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = BASE + 32'h300;
    tick();
    bus.redirect_i = 1'b0;
    check("t4_flush_valid", bus.inst_valid_o, 0);
    mem_auto = 1'b1;
    wait_inst(20);
    check("t4_valid", bus.inst_valid_o, 1);
    check("t4_pc",    bus.pc_o,         BASE + 32'h300);
    check("t4_inst",  bus.inst_o,       BASE + 32'h300);

    // ebreak halts fetch; a redirect resumes it.
    mode = 1;
    bus.inst_ready_i = 1'b1;
    reset_dut();
    mem_auto = 1'b1;
    for (int i = 0; i < 20 && !(bus.inst_valid_o === 1'b1 && bus.inst_o === EBREAK); i++) tick();
    check("t5_ebreak_inst", bus.inst_o, EBREAK);
    check("t5_ebreak_pc",   bus.pc_o,   BASE + 32'h4);
    tick();
    check("t5_halted",    bus.halted_o,    1);
    check("t5_req_valid", bus.req_valid_o, 0);
    tick();
    tick();
    check("t5_still_halted", bus.halted_o, 1);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = BASE + 32'h200;
    tick();
    bus.redirect_i = 1'b0;
    #1;
    check("t5_resume_halted", bus.halted_o,    0);
    check("t5_resume_valid",  bus.req_valid_o, 1);
    check("t5_resume_addr",   bus.req_addr_o,  BASE + 32'h200);
    wait_inst(20);
    check("t5_valid", bus.inst_valid_o, 1);
    check("t5_pc",    bus.pc_o,         BASE + 32'h200);

    // Illegal flag follows the head entry.
    mode = 2;
    bus.inst_ready_i = 1'b0;
    reset_dut();
    mem_auto = 1'b1;
    repeat (8) tick();
    check("t6_valid",    bus.inst_valid_o, 1);
    check("t6_pc0",      bus.pc_o,         BASE);
    check("t6_invalid0", bus.invalid_o,    EXP_ILL0);
    bus.inst_ready_i = 1'b1;
    tick();
    bus.inst_ready_i = 1'b0;
    check("t6_pc1",      bus.pc_o,      BASE + 32'h4);
    check("t6_inst1",    bus.inst_o,    32'h0000_0013);
    check("t6_invalid1", bus.invalid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
